// File: rtl/spi_xip_pkg.sv
// Shared constants and types for the SPI execute-in-place sequencer.
// Contents: SPI master register offsets, the XIP CTRL word, the GO_BSY bit index,
// the flash read command, the sequencer state enum and small helper functions.
package spi_xip_pkg;

  // SPI master register offsets (low 5 address bits)
  localparam logic [4:0] REG_RX0     = 5'h00;
  localparam logic [4:0] REG_TX0     = 5'h00;
  localparam logic [4:0] REG_TX1     = 5'h04;
  localparam logic [4:0] REG_CTRL    = 5'h10;
  localparam logic [4:0] REG_DIVIDER = 5'h14;
  localparam logic [4:0] REG_SS      = 5'h18;

  // CHAR_LEN=64 (encoded as 0x40), Tx_NEG=1, GO_BSY=1
  localparam logic [31:0] XIP_CTRL_VAL = 32'h0000_0540;
  localparam int          GO_BSY_BIT   = 8;
  localparam logic [7:0]  READ_CMD     = 8'h03;

  typedef enum logic [3:0] {
    IDLE, PASS, X_TX1, X_DIV, X_SS, X_CTRL, X_POLL, X_RX, X_SS0, RESP
  } state_e;

  // Flash shifts the first byte into the MSB; the bus wants it in the LSB.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // States that own exactly one downstream APB transaction.
  function automatic logic is_txn(input state_e s);
    return (s inside {PASS, X_TX1, X_DIV, X_SS, X_CTRL, X_POLL, X_RX, X_SS0});
  endfunction

endpackage

// File: rtl/apb_master_port.sv
// APB master phase engine: turns a start pulse into a setup + access transaction.
// Latency: setup in the cycle after i_start, access from the next cycle until i_pready.
// Backpressure: access phase is held while i_pready=0; a start coincident with o_done
// chains the next setup with no idle cycle. Starts while mid-transaction are ignored.
// Ports: i_start/i_addr/i_wdata/i_write/i_pstrb/i_pprot (command), o_done/o_rdata/o_err
// (completion), o_busy, o_p* (APB request), i_pready/i_prdata/i_pslverr (APB response).
module apb_master_port (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_write,
  input  logic [3:0]  i_pstrb,
  input  logic [2:0]  i_pprot,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy,
  output logic [31:0] o_paddr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  output logic [3:0]  o_pstrb,
  output logic [2:0]  o_pprot,
  input  logic        i_pready,
  input  logic [31:0] i_prdata,
  input  logic        i_pslverr
);

  logic        r_psel;
  logic        r_penable;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;
  logic [3:0]  r_pstrb;
  logic [2:0]  r_pprot;
  logic        w_done;

  assign w_done = r_psel && r_penable && i_pready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
    end else if (i_start && (!r_psel || w_done)) begin
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
      r_paddr   <= i_addr;
      r_pwdata  <= i_wdata;
      r_pwrite  <= i_write;
      r_pstrb   <= i_pstrb;
      r_pprot   <= i_pprot;
    end else if (w_done) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else if (r_psel) begin
      r_penable <= 1'b1;
    end
  end

  assign o_done    = w_done;
  assign o_rdata   = i_prdata;
  assign o_err     = i_pslverr;
  assign o_busy    = r_psel;
  assign o_paddr   = r_paddr;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;
  assign o_pwdata  = r_pwdata;
  assign o_pstrb   = r_pstrb;
  assign o_pprot   = r_pprot;

endmodule

// File: rtl/spi_xip_ctrl.sv
// XIP sequencer: APB reads in the flash window become a fixed SPI-master access
// sequence (TX1, DIVIDER, SS, CTRL, poll, RX0, SS=0); other addresses pass through.
// Latency: pass-through 4 cycles setup-to-pready, XIP 16 + 2 per extra busy poll
// (zero-wait downstream); waits on out_pready, upstream held by APB access phase.
// Ports: clock, reset (async active-low), in_* upstream APB slave, out_* APB master.
module spi_xip_ctrl
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] flash_addr_start = 32'h3000_0000,
  parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
  parameter logic [31:0] spi_divider      = 32'h0000_0001,
  parameter logic [7:0]  spi_ss_mask      = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  input  logic [2:0]  in_pprot,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  output logic [2:0]  out_pprot,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  state_e      r_state;
  state_e      w_next;
  state_e      w_cmd_state;
  logic [23:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [2:0]  r_prot;
  logic        r_write;
  logic        r_err;
  logic [31:0] r_rxbuf;
  logic [31:0] r_prdata;

  logic        w_req;
  logic        w_in_window;
  logic        w_start;
  logic        w_done;
  logic        w_busy;
  logic [31:0] w_rdata;
  logic        w_err;
  logic [31:0] w_cmd_addr;
  logic [31:0] w_cmd_wdata;
  logic        w_cmd_write;
  logic [3:0]  w_cmd_strb;

  assign w_req       = in_psel && !in_penable;
  assign w_in_window = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (!w_in_window)   w_next = PASS;
          else if (in_pwrite) w_next = RESP;
          else                w_next = X_TX1;
        end
      end
      PASS:   if (w_done) w_next = RESP;
      X_TX1:  if (w_done) w_next = X_DIV;
      X_DIV:  if (w_done) w_next = X_SS;
      X_SS:   if (w_done) w_next = X_CTRL;
      X_CTRL: if (w_done) w_next = X_POLL;
      X_POLL: if (w_done) w_next = w_rdata[GO_BSY_BIT] ? X_POLL : X_RX;
      X_RX:   if (w_done) w_next = X_SS0;
      X_SS0:  if (w_done) w_next = RESP;
      RESP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The first transaction of a sequence is issued on the cycle the port is
  // seen idle; later ones are issued on the completing cycle of the previous
  // one so setup phases follow access phases with no gap.
  assign w_cmd_state = w_done ? w_next : r_state;
  assign w_start     = (is_txn(r_state) && !w_busy) || (w_done && is_txn(w_next));

  always_comb begin
    w_cmd_addr  = '0;
    w_cmd_wdata = '0;
    w_cmd_write = 1'b0;
    w_cmd_strb  = '0;
    case (w_cmd_state)
      PASS: begin
        w_cmd_addr  = {27'b0, r_addr[4:0]};
        w_cmd_wdata = r_wdata;
        w_cmd_write = r_write;
        w_cmd_strb  = r_strb;
      end
      X_TX1: begin
        w_cmd_addr  = {27'b0, REG_TX1};
        w_cmd_wdata = {READ_CMD, r_addr[23:2], 2'b00};
        w_cmd_write = 1'b1;
        w_cmd_strb  = 4'hf;
      end
      X_DIV: begin
        w_cmd_addr  = {27'b0, REG_DIVIDER};
        w_cmd_wdata = spi_divider;
        w_cmd_write = 1'b1;
        w_cmd_strb  = 4'hf;
      end
      X_SS: begin
        w_cmd_addr  = {27'b0, REG_SS};
        w_cmd_wdata = {24'b0, spi_ss_mask};
        w_cmd_write = 1'b1;
        w_cmd_strb  = 4'hf;
      end
      X_CTRL: begin
        w_cmd_addr  = {27'b0, REG_CTRL};
        w_cmd_wdata = XIP_CTRL_VAL;
        w_cmd_write = 1'b1;
        w_cmd_strb  = 4'hf;
      end
      X_POLL: w_cmd_addr = {27'b0, REG_CTRL};
      X_RX:   w_cmd_addr = {27'b0, REG_RX0};
      X_SS0: begin
        w_cmd_addr  = {27'b0, REG_SS};
        w_cmd_write = 1'b1;
        w_cmd_strb  = 4'hf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_prot   <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_rxbuf  <= '0;
      r_prdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_addr  <= in_paddr[23:0];
        r_wdata <= in_pwdata;
        r_strb  <= in_pstrb;
        r_prot  <= in_pprot;
        r_write <= in_pwrite;
        // Writes into the flash window are rejected without touching the SPI.
        r_err   <= w_in_window && in_pwrite;
        if (w_in_window && in_pwrite) r_prdata <= '0;
      end
      if (w_done) begin
        case (r_state)
          PASS: begin
            r_prdata <= w_rdata;
            r_err    <= w_err;
          end
          X_RX: begin
            r_rxbuf <= bswap32(w_rdata);
            r_err   <= r_err | w_err;
          end
          X_SS0: begin
            r_prdata <= r_rxbuf;
            r_err    <= r_err | w_err;
          end
          // Errors stay sticky so the sequence still deselects the flash.
          default: r_err <= r_err | w_err;
        endcase
      end
    end
  end

  assign in_pready  = (r_state == RESP);
  assign in_pslverr = (r_state == RESP) && r_err;
  assign in_prdata  = r_prdata;

  apb_master_port u_port (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_start   (w_start),
    .i_addr    (w_cmd_addr),
    .i_wdata   (w_cmd_wdata),
    .i_write   (w_cmd_write),
    .i_pstrb   (w_cmd_strb),
    .i_pprot   (r_prot),
    .o_done    (w_done),
    .o_rdata   (w_rdata),
    .o_err     (w_err),
    .o_busy    (w_busy),
    .o_paddr   (out_paddr),
    .o_psel    (out_psel),
    .o_penable (out_penable),
    .o_pwrite  (out_pwrite),
    .o_pwdata  (out_pwdata),
    .o_pstrb   (out_pstrb),
    .o_pprot   (out_pprot),
    .i_pready  (out_pready),
    .i_prdata  (out_prdata),
    .i_pslverr (out_pslverr)
  );

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Testbench for spi_xip_ctrl: zero-wait SPI master model with a GO_BSY busy
// counter and optional pslverr on the SS select write; downstream accesses and
// upstream responses are checked against scoreboard queues.
module tb_spi_xip_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic [2:0]  in_pprot;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic [2:0]  out_pprot;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  spi_xip_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .in_paddr    (in_paddr),
    .in_psel     (in_psel),
    .in_penable  (in_penable),
    .in_pwrite   (in_pwrite),
    .in_pwdata   (in_pwdata),
    .in_pstrb    (in_pstrb),
    .in_pprot    (in_pprot),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_pslverr  (in_pslverr),
    .out_paddr   (out_paddr),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pwrite  (out_pwrite),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_pprot   (out_pprot),
    .out_pready  (out_pready),
    .out_prdata  (out_prdata),
    .out_pslverr (out_pslverr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  txn_t  exp_q[$];
  resp_t resp_q[$];

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          dn_count = 0;
  int          ctrl_reads = 0;
  bit          mon_en = 1'b1;
  logic        err_ss = 1'b0;
  int          busy_set = 0;
  int          poll_cnt;
  logic [31:0] rx_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SPI master model: zero-wait, CTRL reads busy for busy_set polls after a CTRL write.
  always_comb begin
    out_pready  = out_psel && out_penable;
    out_prdata  = '0;
    if (out_paddr == 32'h10)      out_prdata = (poll_cnt < busy_set) ? 32'h540 : 32'h440;
    else if (out_paddr == 32'h00) out_prdata = rx_word;
    out_pslverr = err_ss && out_psel && out_penable && out_pwrite &&
                  (out_paddr == 32'h18) && (out_pwdata == 32'h1);
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) poll_cnt <= 0;
    else if (out_psel && out_penable && out_pready && out_paddr == 32'h10)
      poll_cnt <= out_pwrite ? 0 : poll_cnt + 1;
  end

  // Downstream monitor: pops one expected access per completed transaction.
  always @(negedge clock) begin : mon
    txn_t e;
    if (reset && out_psel && out_penable && out_pready) begin
      dn_count++;
      if (out_paddr == 32'h10 && !out_pwrite) ctrl_reads++;
      if (mon_en) begin
        check("dn_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("dn_addr", out_paddr, e.addr);
          check("dn_write", 32'(out_pwrite), 32'(e.write));
          check("dn_prot", 32'(out_pprot), 32'(e.prot));
          if (e.write) begin
            check("dn_wdata", out_pwdata, e.wdata);
            check("dn_strb", 32'(out_pstrb), 32'(e.strb));
          end
        end
      end
    end
  end

  function automatic void push_w(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic [2:0] p);
    txn_t t;
    t.addr = a; t.write = 1'b1; t.wdata = d; t.strb = s; t.prot = p;
    exp_q.push_back(t);
  endfunction

  function automatic void push_r(input logic [31:0] a, input logic [2:0] p);
    txn_t t;
    t.addr = a; t.write = 1'b0; t.wdata = '0; t.strb = '0; t.prot = p;
    exp_q.push_back(t);
  endfunction

  function automatic void push_xip(input logic [31:0] tx1, input int polls, input logic [2:0] p);
    push_w(32'h04, tx1, 4'hf, p);
    push_w(32'h14, 32'h0000_0001, 4'hf, p);
    push_w(32'h18, 32'h0000_0001, 4'hf, p);
    push_w(32'h10, 32'h0000_0540, 4'hf, p);
    for (int i = 0; i <= polls; i++) push_r(32'h10, p);
    push_r(32'h00, p);
    push_w(32'h18, 32'h0, 4'hf, p);
  endfunction

  function automatic void push_resp(input logic [31:0] d, input logic e);
    resp_t r;
    r.data = d; r.err = e;
    resp_q.push_back(r);
  endfunction

  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p,
                          output logic [31:0] rd, output logic er, output int lat);
    @(negedge clock);
    in_paddr = a; in_pwrite = w; in_pwdata = d; in_pstrb = s; in_pprot = p;
    in_psel = 1'b1; in_penable = 1'b0;
    @(negedge clock);
    in_penable = 1'b1;
    lat = 1;
    while (in_pready !== 1'b1 && lat < 400) begin
      @(negedge clock);
      lat++;
    end
    check("pready_within_bound", 32'(lat < 400), 32'd1);
    rd = in_prdata;
    er = in_pslverr;
    @(negedge clock);
    check("pready_one_cycle", 32'(in_pready), 32'd0);
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rd, input logic er);
    resp_t r;
    r = resp_q.pop_front();
    check({tag, "_prdata"}, rd, r.data);
    check({tag, "_pslverr"}, 32'(er), 32'(r.err));
    check({tag, "_dn_done"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, lat0, dn_before;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    in_pwdata = '0; in_pstrb = '0; in_pprot = '0;
    repeat (2) @(negedge clock);
    check("rst_out_psel", 32'(out_psel), 32'd0);
    check("rst_out_penable", 32'(out_penable), 32'd0);
    check("rst_out_paddr", out_paddr, 32'd0);
    check("rst_out_pwdata", out_pwdata, 32'd0);
    check("rst_out_ctl", 32'({out_pwrite, out_pstrb, out_pprot}), 32'd0);
    check("rst_in_pready", 32'(in_pready), 32'd0);
    check("rst_in_prdata", in_prdata, 32'd0);
    check("rst_in_pslverr", 32'(in_pslverr), 32'd0);
    reset = 1'b1;

    // XIP read, flash bytes 11 22 33 44
    rx_word = 32'h1122_3344; busy_set = 0;
    push_xip(32'h0300_0104, 0, 3'b010);
    push_resp(32'h4433_2211, 1'b0);
    apb_xfer(32'h3000_0104, 1'b0, 32'h0, 4'h0, 3'b010, rd, er, lat0);
    check_resp("xip_basic", rd, er);

    // GO_BSY reported for 5 polls
    rx_word = 32'hA1B2_C3D4; busy_set = 5; ctrl_reads = 0;
    push_xip(32'h0300_0200, 5, 3'b000);
    push_resp(32'hD4C3_B2A1, 1'b0);
    apb_xfer(32'h3000_0200, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    check_resp("xip_busy", rd, er);
    check("busy_ctrl_reads", 32'(ctrl_reads), 32'd6);
    check("busy_extra_latency", 32'(lat - lat0), 32'd10);
    busy_set = 0;

    // pass-through write outside the window
    push_w(32'h14, 32'h1234_5678, 4'hC, 3'b001);
    push_resp(32'h0, 1'b0);
    apb_xfer(32'h0000_0034, 1'b1, 32'h1234_5678, 4'hC, 3'b001, rd, er, lat);
    check_resp("pass_wr", rd, er);
    check("pass_latency", 32'(lat), 32'd4);

    // pass-through read just above the window end
    rx_word = 32'hCAFE_F00D;
    push_r(32'h00, 3'b000);
    push_resp(32'hCAFE_F00D, 1'b0);
    apb_xfer(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    check_resp("pass_rd_above", rd, er);

    // pass-through read just below the window start
    push_r(32'h1C, 3'b000);
    push_resp(32'h0, 1'b0);
    apb_xfer(32'h2FFF_FFFC, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    check_resp("pass_rd_below", rd, er);

    // write into the window is rejected without downstream traffic
    dn_before = dn_count;
    apb_xfer(32'h3000_0000, 1'b1, 32'hDEAD_BEEF, 4'hf, 3'b000, rd, er, lat);
    check("win_wr_pslverr", 32'(er), 32'd1);
    check("win_wr_latency", 32'(lat), 32'd1);
    check("win_wr_no_dn", 32'(dn_count - dn_before), 32'd0);

    // downstream error on the SS select, at the last word of the window
    err_ss = 1'b1; rx_word = 32'h0102_0304;
    push_xip(32'h03FF_FFFC, 0, 3'b000);
    push_resp(32'h0403_0201, 1'b1);
    apb_xfer(32'h3FFF_FFFC, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    check_resp("xip_ss_err", rd, er);
    err_ss = 1'b0;

    // reset while polling GO_BSY
    busy_set = 1000; mon_en = 1'b0; ctrl_reads = 0;
    @(negedge clock);
    in_paddr = 32'h3000_0000; in_pwrite = 1'b0; in_pstrb = 4'h0; in_pprot = 3'b000;
    in_psel = 1'b1; in_penable = 1'b0;
    @(negedge clock);
    in_penable = 1'b1;
    for (int k = 0; k < 100 && ctrl_reads < 2; k++) @(negedge clock);
    check("poll_reached", 32'(ctrl_reads >= 2), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_out_psel", 32'(out_psel), 32'd0);
    check("arst_out_penable", 32'(out_penable), 32'd0);
    check("arst_out_paddr", out_paddr, 32'd0);
    check("arst_out_pwdata", out_pwdata, 32'd0);
    check("arst_out_ctl", 32'({out_pwrite, out_pstrb, out_pprot}), 32'd0);
    check("arst_in_pready", 32'(in_pready), 32'd0);
    in_psel = 1'b0; in_penable = 1'b0;
    @(negedge clock);
    reset = 1'b1; busy_set = 0; mon_en = 1'b1;
    exp_q.delete();

    rx_word = 32'h5566_7788;
    push_xip(32'h0300_0000, 0, 3'b000);
    push_resp(32'h8877_6655, 1'b0);
    apb_xfer(32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    check_resp("after_rst", rd, er);

    // two back-to-back XIP reads
    rx_word = 32'h0A0B_0C0D;
    push_xip(32'h0300_0010, 0, 3'b000);
    push_resp(32'h0D0C_0B0A, 1'b0);
    apb_xfer(32'h3000_0010, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    check_resp("b2b_first", rd, er);
    rx_word = 32'hF0E0_D0C0;
    push_xip(32'h0300_0020, 0, 3'b000);
    push_resp(32'hC0D0_E0F0, 1'b0);
    apb_xfer(32'h3000_0020, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    check_resp("b2b_second", rd, er);

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
